// File: rtl/sw_cond_pkg.sv
// sw_cond_pkg: shared constants and helpers for the switch input conditioner.
//   DEF_WIDTH      - default number of conditioned switch bits
//   SIM_DEBOUNCE   - short debounce window used in simulation builds
//   BOARD_DEBOUNCE - debounce window for real hardware (~10 ms at 100 MHz)
//   cnt_width()    - counter width able to hold 0..cycles
package sw_cond_pkg;

    localparam int DEF_WIDTH      = 5;
    localparam int SIM_DEBOUNCE   = 16;
    localparam int BOARD_DEBOUNCE = 1_000_000;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: one switch bit -> 2-flop synchronizer + debounce counter.
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   raw       in   raw asynchronous switch level
//   stable    out  debounced level
//   rise      out  registered 1-cycle pulse on stable 0->1
//   fall      out  registered 1-cycle pulse on stable 1->0
//   pulse_nxt out  combinational "stable changes at the next edge" (for the top's OR)
module sw_debounce_bit
    import sw_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic pulse_nxt
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;

    // Counter restarts whenever the synchronized level agrees with the stable
    // level, and after acceptance; it therefore never exceeds LAST.
    always_comb begin
        accept  = (sync2 != stable) && (cnt == LAST);
        cnt_nxt = (sync2 == stable || accept) ? '0 : cnt + 1'b1;
    end

    assign pulse_nxt = accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            cnt    <= cnt_nxt;
            stable <= stable ^ accept;
            rise   <= accept & sync2;
            fall   <= accept & ~sync2;
        end
    end

endmodule

// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner: synchronizes and debounces the raw SW bus for the CPU top.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sw_raw     in   [WIDTH] raw asynchronous switch inputs
//   sw_out     out  [WIDTH] debounced stable levels
//   sw_rise    out  [WIDTH] 1-cycle pulse per bit on 0->1
//   sw_fall    out  [WIDTH] 1-cycle pulse per bit on 1->0
//   sw_changed out  1-cycle pulse when any bit rose or fell
module sw_input_conditioner
    import sw_cond_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    logic [WIDTH-1:0] pulse_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw      (sw_raw[i]),
            .stable   (sw_out[i]),
            .rise     (sw_rise[i]),
            .fall     (sw_fall[i]),
            .pulse_nxt(pulse_nxt[i])
        );
    end

    // Built from the per-bit next-pulse terms so sw_changed lands on the same
    // edge as the rise/fall pulses rather than one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sw_changed <= 1'b0;
        else        sw_changed <= |pulse_nxt;
    end

endmodule

// File: tb/tb_sw_input_conditioner.sv
// tb_sw_input_conditioner: directed + randomized bench with a window-based reference model.
module tb_sw_input_conditioner;

    localparam int W = 5;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_out, sw_rise, sw_fall;
    logic         sw_changed;

    int n_checks = 0;
    int n_errors = 0;
    logic mon_en = 1'b0;

    sw_input_conditioner #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .sw_out    (sw_out),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    always #100 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a bit is accepted when the last D synchronized samples
    // (raw delayed by two edges) all differ from the current stable level.
    logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
    logic         m_chg;
    logic [W-1:0] hist[$];

    always @(posedge clk or negedge rst_n) begin : model
        logic [W-1:0] acc;
        if (!rst_n) begin
            m_s1 <= '0; m_s2 <= '0; m_out <= '0;
            m_rise <= '0; m_fall <= '0; m_chg <= 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            acc = (hist.size() == D) ? '1 : '0;
            foreach (hist[k]) acc &= hist[k] ^ m_out;
            m_rise <= acc & m_s2;
            m_fall <= acc & ~m_s2;
            m_chg  <= |acc;
            m_out  <= m_out ^ acc;
            m_s2   <= m_s1;
            m_s1   <= sw_raw;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("out", sw_out, m_out);
            check("rise", sw_rise, m_rise);
            check("fall", sw_fall, m_fall);
            check("changed", sw_changed, m_chg);
            check("rise_fall_overlap", sw_rise & sw_fall, 0);
            check("no_x", $isunknown({sw_out, sw_rise, sw_fall, sw_changed}), 0);
        end
    end

    always @(sw_out) begin
        if (mon_en && rst_n) check("out_on_edge", clk, 1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [W-1:0] raw);
        rst_n  = 1'b0;
        sw_raw = raw;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        sw_raw = 5'b10101;
        rst_n  = 1'b0;
        repeat (2) step();
        mon_en = 1'b1;
        check("rst_out", sw_out, 0);
        check("rst_rise", sw_rise, 0);
        check("rst_changed", sw_changed, 0);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 5) check("pwr_out_e5", sw_out, 0);
            if (e == 6) begin
                check("pwr_out_e6", sw_out, 5'b10101);
                check("pwr_rise_e6", sw_rise, 5'b10101);
                check("pwr_chg_e6", sw_changed, 1);
            end
            if (e == 7) begin
                check("pwr_rise_e7", sw_rise, 0);
                check("pwr_chg_e7", sw_changed, 0);
            end
        end

        do_reset('0);
        repeat (3) step();
        sw_raw[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 5) check("step_out_e5", sw_out, 0);
            if (e == 6) begin
                check("step_out_e6", sw_out, 5'b00001);
                check("step_rise_e6", sw_rise, 5'b00001);
                check("step_fall_e6", sw_fall, 0);
            end
            if (e == 7) check("step_rise_e7", sw_rise, 0);
        end

        sw_raw[2] = 1'b1;
        repeat (3) step();
        sw_raw[2] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            check("glitch_out", sw_out, 5'b00001);
            check("glitch_chg", sw_changed, 0);
            step();
        end
        sw_raw[2] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 4) sw_raw[2] = 1'b0;
            if (e == 6) begin
                check("hold4_out", sw_out, 5'b00101);
                check("hold4_rise", sw_rise, 5'b00100);
            end
        end
        repeat (10) step();

        do_reset('0);
        repeat (3) step();
        sw_raw = 5'b11000;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 6) begin
                check("simul_rise", sw_rise, 5'b11000);
                check("simul_chg", sw_changed, 1);
            end
            if (e == 7) check("simul_chg_e7", sw_changed, 0);
        end
        sw_raw = 5'b01000;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 6) check("simul_fall", sw_fall, 5'b10000);
        end

        sw_raw = 5'b01001;
        repeat (2) step();
        #50 rst_n = 1'b0;
        #1;
        check("async_out", sw_out, 0);
        check("async_rise", sw_rise, 0);
        check("async_chg", sw_changed, 0);
        #50 rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 5) check("async_out_e5", sw_out, 0);
            if (e == 6) begin
                check("async_out_e6", sw_out, 5'b01001);
                check("async_rise_e6", sw_rise, 5'b01001);
            end
        end

        for (int c = 0; c < 300; c++) begin
            step();
            if ($urandom_range(3) == 0) sw_raw = W'($urandom);
        end

        @(posedge clk);
        #5;
        for (int i = 0; i < 400; i++) begin
            sw_raw = sw_raw + 1'b1;
            #10;
        end
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
